// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between icache fetches and dcache fills/write-backs
module mem_port_arbiter #(
   parameter int ADDR_WIDTH   = 32,
   parameter int LINE_WIDTH   = 128,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  ic_req_valid_i,
   input  logic [ADDR_WIDTH-1:0] ic_req_addr_i,
   output logic                  ic_req_ready_o,
   output logic                  ic_resp_valid_o,
   output logic [LINE_WIDTH-1:0] ic_resp_data_o,
   input  logic                  dc_req_valid_i,
   input  logic [ADDR_WIDTH-1:0] dc_req_addr_i,
   input  logic                  dc_req_we_i,
   input  logic [LINE_WIDTH-1:0] dc_req_wdata_i,
   output logic                  dc_req_ready_o,
   output logic                  dc_resp_valid_o,
   output logic [LINE_WIDTH-1:0] dc_resp_data_o,
   output logic                  mem_req_valid_o,
   output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
   output logic                  mem_req_we_o,
   output logic [LINE_WIDTH-1:0] mem_req_wdata_o,
   input  logic                  mem_req_ready_i,
   input  logic                  mem_resp_valid_i,
   input  logic [LINE_WIDTH-1:0] mem_resp_data_i
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP} state_t;
   typedef enum logic [1:0] {OWN_NONE, OWN_IC, OWN_DC} owner_t;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   state_t                state_q, state_d;
   owner_t                owner_q, owner_d;
   logic [3:0]            starve_cnt_q, starve_cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  we_q, we_d;
   logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
   logic [LINE_WIDTH-1:0] ic_resp_data_q, ic_resp_data_d;
   logic [LINE_WIDTH-1:0] dc_resp_data_q, dc_resp_data_d;
   logic                  ic_resp_valid_q, ic_resp_valid_d;
   logic                  dc_resp_valid_q, dc_resp_valid_d;
   logic                  grant_ic, grant_dc;

   // Data side wins ties unless fetch has already lost STARVE_LIMIT times in a row.
   always_comb begin
      grant_ic = 1'b0;
      grant_dc = 1'b0;
      if (state_q == IDLE && !reset_i) begin
         if (ic_req_valid_i && dc_req_valid_i) begin
            if (starve_cnt_q == LIMIT) grant_ic = 1'b1;
            else                       grant_dc = 1'b1;
         end else begin
            grant_ic = ic_req_valid_i;
            grant_dc = dc_req_valid_i;
         end
      end
   end

   always_comb begin
      state_d         = state_q;
      owner_d         = owner_q;
      starve_cnt_d    = starve_cnt_q;
      addr_d          = addr_q;
      we_d            = we_q;
      wdata_d         = wdata_q;
      ic_resp_data_d  = ic_resp_data_q;
      dc_resp_data_d  = dc_resp_data_q;
      ic_resp_valid_d = 1'b0;
      dc_resp_valid_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (grant_ic) begin
               state_d      = REQ;
               owner_d      = OWN_IC;
               addr_d       = ic_req_addr_i;
               we_d         = 1'b0;
               wdata_d      = '0;
               starve_cnt_d = '0;
            end else if (grant_dc) begin
               state_d = REQ;
               owner_d = OWN_DC;
               addr_d  = dc_req_addr_i;
               we_d    = dc_req_we_i;
               wdata_d = dc_req_wdata_i;
               if (ic_req_valid_i && starve_cnt_q != LIMIT)
                  starve_cnt_d = starve_cnt_q + 4'd1;
            end
         end
         REQ: begin
            if (mem_req_ready_i) state_d = WAIT_RESP;
         end
         WAIT_RESP: begin
            if (mem_resp_valid_i) begin
               state_d = IDLE;
               owner_d = OWN_NONE;
               if (owner_q == OWN_IC) begin
                  ic_resp_valid_d = 1'b1;
                  ic_resp_data_d  = mem_resp_data_i;
               end else if (owner_q == OWN_DC) begin
                  dc_resp_valid_d = 1'b1;
                  dc_resp_data_d  = mem_resp_data_i;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q         <= IDLE;
         owner_q         <= OWN_NONE;
         starve_cnt_q    <= '0;
         addr_q          <= '0;
         we_q            <= 1'b0;
         wdata_q         <= '0;
         ic_resp_data_q  <= '0;
         dc_resp_data_q  <= '0;
         ic_resp_valid_q <= 1'b0;
         dc_resp_valid_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         owner_q         <= owner_d;
         starve_cnt_q    <= starve_cnt_d;
         addr_q          <= addr_d;
         we_q            <= we_d;
         wdata_q         <= wdata_d;
         ic_resp_data_q  <= ic_resp_data_d;
         dc_resp_data_q  <= dc_resp_data_d;
         ic_resp_valid_q <= ic_resp_valid_d;
         dc_resp_valid_q <= dc_resp_valid_d;
      end
   end

   assign ic_req_ready_o  = grant_ic;
   assign dc_req_ready_o  = grant_dc;
   assign ic_resp_valid_o = ic_resp_valid_q;
   assign ic_resp_data_o  = ic_resp_data_q;
   assign dc_resp_valid_o = dc_resp_valid_q;
   assign dc_resp_data_o  = dc_resp_data_q;
   assign mem_req_valid_o = (state_q == REQ);
   assign mem_req_addr_o  = addr_q;
   assign mem_req_we_o    = we_q;
   assign mem_req_wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized bench for mem_port_arbiter against a transaction-level model
module tb_mem_port_arbiter;
   localparam int AW    = 32;
   localparam int LW    = 128;
   localparam int LIMIT = 2;
   localparam int NCYC  = 4000;

   logic          clk_i = 1'b0;
   logic          reset_i;
   logic          ic_req_valid_i, ic_req_ready_o, ic_resp_valid_o;
   logic [AW-1:0] ic_req_addr_i;
   logic [LW-1:0] ic_resp_data_o;
   logic          dc_req_valid_i, dc_req_we_i, dc_req_ready_o, dc_resp_valid_o;
   logic [AW-1:0] dc_req_addr_i;
   logic [LW-1:0] dc_req_wdata_i, dc_resp_data_o;
   logic          mem_req_valid_o, mem_req_we_o, mem_req_ready_i, mem_resp_valid_i;
   logic [AW-1:0] mem_req_addr_o;
   logic [LW-1:0] mem_req_wdata_o, mem_resp_data_i;

   always #5 clk_i = ~clk_i;

   mem_port_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .STARVE_LIMIT(LIMIT)) dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .ic_req_valid_i(ic_req_valid_i), .ic_req_addr_i(ic_req_addr_i), .ic_req_ready_o(ic_req_ready_o),
      .ic_resp_valid_o(ic_resp_valid_o), .ic_resp_data_o(ic_resp_data_o),
      .dc_req_valid_i(dc_req_valid_i), .dc_req_addr_i(dc_req_addr_i), .dc_req_we_i(dc_req_we_i),
      .dc_req_wdata_i(dc_req_wdata_i), .dc_req_ready_o(dc_req_ready_o),
      .dc_resp_valid_o(dc_resp_valid_o), .dc_resp_data_o(dc_resp_data_o),
      .mem_req_valid_o(mem_req_valid_o), .mem_req_addr_o(mem_req_addr_o), .mem_req_we_o(mem_req_we_o),
      .mem_req_wdata_o(mem_req_wdata_o), .mem_req_ready_i(mem_req_ready_i),
      .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_data_i(mem_resp_data_i)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Backing memory contents; untouched lines read back as their address replicated.
   logic [LW-1:0] mm [logic [AW-1:0]];

   function automatic logic [LW-1:0] read_mem(input logic [AW-1:0] a);
      if (mm.exists(a)) return mm[a];
      return {4{a}};
   endfunction

   // Transaction-level model: one transaction in flight, tracked as busy/issued flags.
   bit            busy, issued;
   int            starve;
   bit            cur_ic, cur_we;
   logic [AW-1:0] cur_addr;
   logic [LW-1:0] cur_wdata;
   bit            exp_ic_pv, exp_dc_pv, dc_data_known;
   logic [LW-1:0] exp_ic_data, exp_dc_data;
   bit            exp_ic_rdy, exp_dc_rdy, ic_taken, dc_taken, rst;
   int            ic_grants, dc_grants, forced_ic;

   initial begin
      reset_i = 1'b1;
      ic_req_valid_i = 1'b0; ic_req_addr_i = '0;
      dc_req_valid_i = 1'b0; dc_req_addr_i = '0; dc_req_we_i = 1'b0; dc_req_wdata_i = '0;
      mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b0; mem_resp_data_i = '0;
      busy = 0; issued = 0; starve = 0;
      exp_ic_pv = 0; exp_dc_pv = 0; dc_data_known = 1;
      exp_ic_data = '0; exp_dc_data = '0;
      ic_taken = 0; dc_taken = 0;
      ic_grants = 0; dc_grants = 0; forced_ic = 0;
      cur_ic = 0; cur_we = 0; cur_addr = '0; cur_wdata = '0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      check("rst_mem_valid", LW'(mem_req_valid_o), '0);
      check("rst_mem_addr", LW'(mem_req_addr_o), '0);
      check("rst_mem_we", LW'(mem_req_we_o), '0);
      check("rst_mem_wdata", mem_req_wdata_o, '0);
      check("rst_ic_ready", LW'(ic_req_ready_o), '0);
      check("rst_dc_ready", LW'(dc_req_ready_o), '0);
      check("rst_ic_data", ic_resp_data_o, '0);
      check("rst_dc_data", dc_resp_data_o, '0);

      for (int cyc = 0; cyc < NCYC; cyc++) begin
         if (cyc > 0) @(negedge clk_i);
         rst = (cyc == 0) || ($urandom_range(0, 149) == 0);
         reset_i = rst;

         // Requesters: hold until accepted, occasionally abandon, re-request often.
         if (ic_taken) begin
            ic_req_valid_i = 1'b0; ic_taken = 0;
         end else if (ic_req_valid_i) begin
            if ($urandom_range(0, 15) == 0) ic_req_valid_i = 1'b0;
         end else if ($urandom_range(0, 3) != 0) begin
            ic_req_valid_i = 1'b1;
            ic_req_addr_i  = AW'($urandom_range(0, 7) * 16);
         end
         if (dc_taken) begin
            dc_req_valid_i = 1'b0; dc_taken = 0;
         end else if (dc_req_valid_i) begin
            if ($urandom_range(0, 15) == 0) dc_req_valid_i = 1'b0;
         end else if ($urandom_range(0, 2) != 0) begin
            dc_req_valid_i = 1'b1;
            dc_req_addr_i  = AW'($urandom_range(0, 7) * 16);
            dc_req_we_i    = 1'($urandom_range(0, 1));
            dc_req_wdata_i = {$urandom, $urandom, $urandom, $urandom};
         end

         // Memory: random accept/response delays plus stray responses outside WAIT_RESP.
         mem_req_ready_i  = 1'b0;
         mem_resp_valid_i = 1'b0;
         if (busy && !issued) mem_req_ready_i = ($urandom_range(0, 2) == 0);
         else if (busy && issued) mem_resp_valid_i = ($urandom_range(0, 2) == 0);
         if (!(busy && issued) && !mem_req_ready_i && $urandom_range(0, 19) == 0)
            mem_resp_valid_i = 1'b1;
         if (busy && issued && !cur_we) mem_resp_data_i = read_mem(cur_addr);
         else mem_resp_data_i = {$urandom, $urandom, $urandom, $urandom};

         #1;
         exp_ic_rdy = 0;
         exp_dc_rdy = 0;
         if (!busy && !rst) begin
            if (ic_req_valid_i && dc_req_valid_i) begin
               if (starve >= LIMIT) exp_ic_rdy = 1;
               else                 exp_dc_rdy = 1;
            end else begin
               exp_ic_rdy = ic_req_valid_i;
               exp_dc_rdy = dc_req_valid_i;
            end
         end
         check("ic_ready", LW'(ic_req_ready_o), LW'(exp_ic_rdy));
         check("dc_ready", LW'(dc_req_ready_o), LW'(exp_dc_rdy));
         check("mem_valid", LW'(mem_req_valid_o), LW'(busy && !issued));
         if (busy && !issued) begin
            check("mem_addr", LW'(mem_req_addr_o), LW'(cur_addr));
            check("mem_we", LW'(mem_req_we_o), LW'(cur_we));
            if (cur_we) check("mem_wdata", mem_req_wdata_o, cur_wdata);
         end
         check("ic_resp_valid", LW'(ic_resp_valid_o), LW'(exp_ic_pv));
         check("dc_resp_valid", LW'(dc_resp_valid_o), LW'(exp_dc_pv));
         check("ic_resp_data", ic_resp_data_o, exp_ic_data);
         if (dc_data_known) check("dc_resp_data", dc_resp_data_o, exp_dc_data);

         // Advance the model across the coming clock edge.
         exp_ic_pv = 0;
         exp_dc_pv = 0;
         if (rst) begin
            busy = 0; issued = 0; starve = 0;
            exp_ic_data = '0; exp_dc_data = '0; dc_data_known = 1;
         end else if (!busy) begin
            if (exp_ic_rdy) begin
               if (dc_req_valid_i) forced_ic++;
               ic_grants++;
               busy = 1; cur_ic = 1; cur_we = 0; cur_addr = ic_req_addr_i; cur_wdata = '0;
               starve = 0; ic_taken = 1;
            end else if (exp_dc_rdy) begin
               dc_grants++;
               busy = 1; cur_ic = 0; cur_we = dc_req_we_i; cur_addr = dc_req_addr_i;
               cur_wdata = dc_req_wdata_i; dc_taken = 1;
               if (ic_req_valid_i && starve < LIMIT) starve++;
            end
         end else if (!issued) begin
            if (mem_req_ready_i) issued = 1;
         end else if (mem_resp_valid_i) begin
            busy = 0; issued = 0;
            if (cur_ic) begin
               exp_ic_pv = 1; exp_ic_data = read_mem(cur_addr);
            end else if (cur_we) begin
               exp_dc_pv = 1; mm[cur_addr] = cur_wdata; dc_data_known = 0;
            end else begin
               exp_dc_pv = 1; exp_dc_data = read_mem(cur_addr); dc_data_known = 1;
            end
         end
      end

      check("ic_grants_seen", LW'(ic_grants > 20), LW'(1));
      check("dc_grants_seen", LW'(dc_grants > 20), LW'(1));
      check("starve_wins_seen", LW'(forced_ic > 0), LW'(1));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported backing memory between the instruction cache (fetch line reads) and the data cache (line fills and write-backs from loads and stores).
- Sits between both cache controllers and the memory interface.
- Allows one outstanding transaction at a time.
- Data requests have priority; a starvation counter bounds how long fetch can be blocked.

Parameters:
- ADDR_WIDTH, 32, byte address width of requests.
- LINE_WIDTH, 128, data width of one cache-line transfer.
- STARVE_LIMIT, 4, number of consecutive data grants, taken while fetch is waiting, before fetch is forced to win. Legal range is 1..15.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- ic_req_valid_i  in  1  icache read request
- ic_req_addr_i  in  ADDR_WIDTH  icache line address
- ic_req_ready_o  out  1  icache request accepted this cycle
- ic_resp_valid_o  out  1  icache read data valid (one-cycle pulse)
- ic_resp_data_o  out  LINE_WIDTH  icache read data
- dc_req_valid_i  in  1  dcache request
- dc_req_addr_i  in  ADDR_WIDTH  dcache line address
- dc_req_we_i  in  1  1 = write-back, 0 = fill
- dc_req_wdata_i  in  LINE_WIDTH  write-back data
- dc_req_ready_o  out  1  dcache request accepted this cycle
- dc_resp_valid_o  out  1  dcache read data or write acknowledge (one-cycle pulse)
- dc_resp_data_o  out  LINE_WIDTH  dcache read data
- mem_req_valid_o  out  1  memory request
- mem_req_addr_o  out  ADDR_WIDTH  memory address
- mem_req_we_o  out  1  memory write enable
- mem_req_wdata_o  out  LINE_WIDTH  memory write data
- mem_req_ready_i  in  1  memory accepts request
- mem_resp_valid_i  in  1  memory response (read data or write acknowledge)
- mem_resp_data_i  in  LINE_WIDTH  memory read data

Behaviour:
- One clock, clk_i; reset_i is synchronous and active-high.
- Reset values:
  - state = IDLE; starve_cnt = 0; owner = none.
  - All *_valid_o = 0 and both *_ready_o = 0.
  - mem_req_addr_o, mem_req_wdata_o and *_resp_data_o = 0; mem_req_we_o = 0.
- FSM states: IDLE, REQ, WAIT_RESP.
- IDLE, grant decision (combinational):
  - Only dc valid -> grant dc.
  - Only ic valid -> grant ic.
  - Both valid -> grant ic if starve_cnt == STARVE_LIMIT, else grant dc.
  - Granted requester sees ready_o = 1 in this same cycle. Only one ready_o is ever high; both are 0 outside IDLE.
  - On grant: register addr, we (ic forces we = 0) and wdata into the mem_req_* registers; record owner; go to REQ.
- REQ:
  - mem_req_valid_o = 1 with stable addr/we/wdata until the cycle mem_req_ready_i = 1.
  - In that cycle, go to WAIT_RESP; mem_req_valid_o drops to 0 on the next cycle.
- WAIT_RESP:
  - On mem_resp_valid_i, register mem_resp_data_i into the owner's resp_data_o and pulse the owner's resp_valid_o for exactly one cycle (the next cycle).
  - Go to IDLE in that same next cycle.
- Latency:
  - Request accepted in cycle N -> mem_req_valid_o = 1 in N+1.
  - Memory response in cycle M -> requester resp_valid_o = 1 in M+1.
  - A new grant is possible in M+1, giving mem_req_valid_o in M+2.
- Starvation counter (updated at grant):
  - Grant dc while ic_req_valid_i = 1 -> starve_cnt + 1, saturating at STARVE_LIMIT.
  - Grant ic -> starve_cnt = 0.
  - Grant dc with ic idle -> starve_cnt unchanged.
- Requester rule: valid, addr, we and wdata stay stable until ready. A requester may drop valid before being granted; no state is affected.
- Memory rules:
  - Memory never asserts mem_resp_valid_i in the same cycle as mem_req_ready_i.
  - mem_resp_valid_i in IDLE or REQ is ignored.
- Write-backs: the acknowledge pulses dc_resp_valid_o; dc_resp_data_o content is don't-care.
- Non-owner outputs: the non-owner's resp_valid_o stays 0; resp_data_o of each requester holds its last value.
- Reset mid-operation (REQ or WAIT_RESP):
  - Immediate return to IDLE with reset values; the outstanding transaction is dropped with no response pulse.
  - The memory side is reset by the same reset_i.

Test Plan:
- Single fetch: ic valid, addr 0x0000_0100 at cycle 0, mem_req_ready_i = 1 at cycle 1, mem resp at cycle 4 with data 0xAAAA… -> ic_req_ready_o at cycle 0; mem_req_valid_o cycles 1..1 with we = 0; ic_resp_valid_o at cycle 5 with data 0xAAAA…; dc_resp_valid_o stays 0.
- Simultaneous requests: ic 0x100 and dc fill 0x200 in the same cycle -> dc granted first, mem_req_addr_o = 0x200; ic granted in the cycle dc_resp_valid_o pulses; ic data is returned afterwards.
- Starvation, STARVE_LIMIT = 2: ic held valid, dc re-requests continuously -> grant order dc, dc, ic, dc, dc, ic; starve_cnt goes 1, 2, then 0.
- Backpressure: dc write-back, addr 0x300, wdata 0x1234…, mem_req_ready_i low for 3 cycles -> mem_req_valid_o high 4 cycles with addr/we = 1/wdata constant; ack yields a one-cycle dc_resp_valid_o.
- Reset in WAIT_RESP: assert reset_i one cycle, then deliver mem_resp_valid_i -> no resp_valid_o pulse, state IDLE, starve_cnt = 0, next ic request accepted immediately.
- Stray response: mem_resp_valid_i in IDLE -> no outputs change.
